// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Define MULDIV_EARLY_OUT_EN to finish zero-operand multiplies and divide-by-zero in one cycle.
module muldiv_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  busy,
    output logic                  done,
    output logic [XLEN-1:0]       result,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

    localparam logic [1:0] OpMul   = 2'b00;
    localparam logic [1:0] OpMulhu = 2'b01;
    localparam logic [1:0] OpDivu  = 2'b10;
    localparam logic [1:0] OpRemu  = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [XLEN-1:0]       a_q, a_d;
    logic [XLEN-1:0]       b_q, b_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;
    logic [XLEN:0]         rem_q, rem_d;
    logic [XLEN-1:0]       quo_q, quo_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;

    logic [2*XLEN-1:0]     addend;
    logic [XLEN:0]         rem_shift;
    logic [XLEN:0]         rem_sub;
    logic                  rem_ge;

    // Dividend is shifted out MSB first from a_q into the remainder.
    assign addend    = {{XLEN{1'b0}}, a_q} << cnt_q;
    assign rem_shift = {rem_q[XLEN-1:0], a_q[XLEN-1]};
    assign rem_sub   = rem_shift - {1'b0, b_q};
    assign rem_ge    = rem_shift >= {1'b0, b_q};

`ifdef MULDIV_EARLY_OUT_EN
    logic early;
    assign early = op[1] ? (rs2_data == '0) : ((rs1_data == '0) || (rs2_data == '0));
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        result_d  = result_q;
        wb_addr_d = wb_addr_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d      = op;
                    a_d       = rs1_data;
                    b_d       = rs2_data;
                    wb_addr_d = rd_addr;
                    cnt_d     = '0;
                    acc_d     = '0;
                    rem_d     = '0;
                    quo_d     = '0;
                    state_d   = StRun;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early) begin
                        unique case (op)
                            OpDivu:  result_d = '1;
                            OpRemu:  result_d = rs1_data;
                            default: result_d = '0;
                        endcase
                        state_d = StDone;
                    end
`endif
                end
            end
            StRun: begin
                if (op_q[1]) begin
                    rem_d = rem_ge ? rem_sub : rem_shift;
                    quo_d = {quo_q[XLEN-2:0], rem_ge};
                    a_d   = a_q << 1;
                end else if (b_q[cnt_q]) begin
                    acc_d = acc_q + addend;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    unique case (op_q)
                        OpMul:   result_d = acc_d[XLEN-1:0];
                        OpMulhu: result_d = acc_d[2*XLEN-1:XLEN];
                        OpDivu:  result_d = quo_d;
                        OpRemu:  result_d = rem_d[XLEN-1:0];
                        default: result_d = '0;
                    endcase
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            wb_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            result_q  <= result_d;
            wb_addr_q <= wb_addr_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign result  = result_q;
    assign wb_addr = wb_addr_q;
    assign wb_en   = done && (wb_addr_q != '0);

endmodule
